rotary_input: RTL and testbench

Input-conditioning stage that sits directly upstream of the LED-matrix/clock logic and turns a raw quadrature rotary encoder plus its push switch into clean control events. It performs the following steps:
- synchronises and debounces the three pins;
- decodes full detents into one-cycle `inc`/`dec` pulses;
- maintains a bounded setting value (for example minutes 0..59) that the display stage consumes directly.

---
 rtl/rotary_input.sv | 150 +++++++++++++++
 tb/tb_rotary_input.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_input.sv
// Quadrature rotary encoder front end: synchronise and debounce the A/B/switch pins,
// decode detents into inc/dec pulses and keep a bounded setting value.
module rotary_input #(
    parameter int DEBOUNCE_CYCLES  = 27000,
    parameter int STEPS_PER_DETENT = 4,
    parameter int VALUE_MAX        = 59,
    parameter int WRAP             = 1,
    localparam int VW              = $clog2(VALUE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rot_a,
    input  logic          rot_b,
    input  logic          rot_sw,
    input  logic          value_clr,
    output logic          inc,
    output logic          dec,
    output logic          sw_press,
    output logic          sw_level,
    output logic [VW-1:0] value,
    output logic          seq_err
);

    localparam int                CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [VW-1:0]     VAL_MAX  = VW'(VALUE_MAX);
    localparam logic signed [3:0] ACC_POS  = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] ACC_NEG  = 4'(-STEPS_PER_DETENT);

    // Bit positions of the three pins in the conditioned vectors.
    localparam int IA  = 0;
    localparam int IB  = 1;
    localparam int ISW = 2;

    logic [2:0]          pins;
    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          deb_q, deb_d;
    logic [2:0][CW-1:0]  cnt_q, cnt_d;
    logic [1:0]          ab_prev_q, ab_prev_d;
    logic [1:0]          ab_cur;
    logic                sw_prev_q, sw_prev_d;
    logic signed [3:0]   acc_q, acc_d;
    logic signed [3:0]   step;
    logic signed [3:0]   acc_sum;
    logic                inc_q, inc_d;
    logic                dec_q, dec_d;
    logic                seq_err_q, seq_err_d;
    logic                sw_press_q, sw_press_d;
    logic                sw_level_q, sw_level_d;
    logic [VW-1:0]       value_q, value_d;

    assign pins = {rot_sw, rot_b, rot_a};

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sync1_d = pins;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i] = '0;
                deb_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Quadrature decode: compare the debounced pair against last cycle's copy.
    always_comb begin
        ab_cur    = {deb_q[IA], deb_q[IB]};
        ab_prev_d = ab_cur;
        step      = 4'sd0;
        seq_err_d = 1'b0;
        case ({ab_prev_q, ab_cur})
            4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: step = 4'sd1;
            4'b10_11, 4'b00_10, 4'b01_00, 4'b11_01: step = -4'sd1;
            4'b11_00, 4'b00_11, 4'b10_01, 4'b01_10: seq_err_d = 1'b1;
            default: ;
        endcase

        acc_sum = acc_q + step;
        inc_d   = (acc_sum == ACC_POS);
        dec_d   = (acc_sum == ACC_NEG);
        acc_d   = (inc_d || dec_d) ? 4'sd0 : acc_sum;
    end

    always_comb begin
        sw_prev_d  = deb_q[ISW];
        sw_press_d = sw_prev_q & ~deb_q[ISW];
        sw_level_d = ~deb_q[ISW];

        // Clear wins over a same-cycle detent; the pulse itself is still emitted.
        value_d = value_q;
        if (value_clr) begin
            value_d = '0;
        end else if (inc_d) begin
            if (value_q >= VAL_MAX) value_d = (WRAP != 0) ? '0 : VAL_MAX;
            else                    value_d = value_q + VW'(1);
        end else if (dec_d) begin
            if (value_q == '0)      value_d = (WRAP != 0) ? VAL_MAX : '0;
            else                    value_d = value_q - VW'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            cnt_q      <= '0;
            ab_prev_q  <= 2'b11;
            sw_prev_q  <= 1'b1;
            acc_q      <= 4'sd0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            seq_err_q  <= 1'b0;
            sw_press_q <= 1'b0;
            sw_level_q <= 1'b0;
            value_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            ab_prev_q  <= ab_prev_d;
            sw_prev_q  <= sw_prev_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            seq_err_q  <= seq_err_d;
            sw_press_q <= sw_press_d;
            sw_level_q <= sw_level_d;
            value_q    <= value_d;
        end
    end

    assign inc      = inc_q;
    assign dec      = dec_q;
    assign seq_err  = seq_err_q;
    assign sw_press = sw_press_q;
    assign sw_level = sw_level_q;
    assign value    = value_q;

endmodule

// File: tb/tb_rotary_input.sv
// Bench for rotary_input: a wrapping and a saturating instance share one stimulus;
// detent pulses are scored against a queue of expected records.
module tb_rotary_input;

    localparam int DC   = 4;
    localparam int SPD  = 4;
    localparam int VMAX = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rot_a = 1'b1;
    logic       rot_b = 1'b1;
    logic       rot_sw = 1'b1;
    logic       value_clr = 1'b0;
    logic       inc, dec, sw_press, sw_level, seq_err;
    logic [2:0] value;
    logic       inc_s, dec_s, sw_press_s, sw_level_s, seq_err_s;
    logic [2:0] value_s;

    rotary_input #(.DEBOUNCE_CYCLES(DC), .STEPS_PER_DETENT(SPD), .VALUE_MAX(VMAX), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .rot_sw(rot_sw),
        .value_clr(value_clr), .inc(inc), .dec(dec), .sw_press(sw_press),
        .sw_level(sw_level), .value(value), .seq_err(seq_err)
    );

    rotary_input #(.DEBOUNCE_CYCLES(DC), .STEPS_PER_DETENT(SPD), .VALUE_MAX(VMAX), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .rot_sw(rot_sw),
        .value_clr(value_clr), .inc(inc_s), .dec(dec_s), .sw_press(sw_press_s),
        .sw_level(sw_level_s), .value(value_s), .seq_err(seq_err_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cw;
        bit clr;
        int val;
        int sat;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   seq_cnt = 0;
    int   press_cnt = 0;
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every detent pulse must match the oldest expected record.
    always @(negedge clk) begin
        vec_t e;
        if (seq_err) seq_cnt++;
        if (sw_press) press_cnt++;
        if (inc || dec) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'b0, inc, dec}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_dir", {30'b0, inc, dec}, {30'b0, e.cw, ~e.cw});
                check("value", {29'b0, value}, e.val);
                check("sat_pulse_dir", {30'b0, inc_s, dec_s}, {30'b0, e.cw, ~e.cw});
                check("value_sat", {29'b0, value_s}, e.sat);
            end
        end else if (inc_s || dec_s) begin
            check("unexpected_sat_pulse", {30'b0, inc_s, dec_s}, 32'd0);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One quadrature phase held 10 cycles; optionally pulse value_clr on the cycle the detent completes.
    task automatic phase(input logic a, input logic b, input bit clr_pulse);
        rot_a = a;
        rot_b = b;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            value_clr = clr_pulse && (i == 2 + DC);
        end
    endtask

    task automatic detent(input bit cw, input bit clr);
        if (cw) begin
            phase(1'b1, 1'b0, 1'b0);
            phase(1'b0, 1'b0, 1'b0);
            phase(1'b0, 1'b1, 1'b0);
            phase(1'b1, 1'b1, clr);
        end else begin
            phase(1'b0, 1'b1, 1'b0);
            phase(1'b0, 1'b0, 1'b0);
            phase(1'b1, 1'b0, 1'b0);
            phase(1'b1, 1'b1, clr);
        end
    endtask

    initial begin
        vec_t tbl[15];
        bit   moved;
        int   s0;
        vec_t post;

        tbl[0]  = '{1'b1, 1'b0, 1, 1};
        tbl[1]  = '{1'b1, 1'b0, 2, 2};
        tbl[2]  = '{1'b1, 1'b0, 3, 3};
        tbl[3]  = '{1'b1, 1'b0, 4, 4};
        tbl[4]  = '{1'b1, 1'b0, 5, 5};
        tbl[5]  = '{1'b1, 1'b0, 0, 5};
        tbl[6]  = '{1'b0, 1'b0, 5, 4};
        tbl[7]  = '{1'b0, 1'b0, 4, 3};
        tbl[8]  = '{1'b0, 1'b0, 3, 2};
        tbl[9]  = '{1'b0, 1'b0, 2, 1};
        tbl[10] = '{1'b0, 1'b0, 1, 0};
        tbl[11] = '{1'b0, 1'b0, 0, 0};
        tbl[12] = '{1'b0, 1'b0, 5, 0};
        tbl[13] = '{1'b1, 1'b1, 0, 0};
        tbl[14] = '{1'b1, 1'b0, 1, 1};

        // Reset held with pins toggling.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rot_a  = i[0];
            rot_b  = i[1];
            rot_sw = i[2];
        end
        check("reset_outputs", {24'b0, inc, dec, sw_press, sw_level, seq_err, value}, 32'd0);
        check("reset_outputs_sat", {24'b0, inc_s, dec_s, sw_press_s, sw_level_s, seq_err_s, value_s}, 32'd0);
        rot_a  = 1'b1;
        rot_b  = 1'b1;
        rot_sw = 1'b1;
        hold(2);
        rst_n = 1'b1;
        hold(50);
        check("quiet_seq_err", seq_cnt, 32'd0);
        check("quiet_press", press_cnt, 32'd0);
        check("quiet_value", {29'b0, value}, 32'd0);

        // Short glitch on A is filtered.
        rot_a = 1'b0;
        hold(3);
        rot_a = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dut.deb_q[0] !== 1'b1) moved = 1'b1;
        end
        check("glitch_no_change", {31'b0, moved}, 32'd0);
        check("glitch_no_seq_err", seq_cnt, 32'd0);

        // Held pulse on A changes the debounced level exactly 2+DC cycles after the pin edge.
        rot_a = 1'b0;
        hold(1 + DC);
        check("deb_before_edge", {31'b0, dut.deb_q[0]}, 32'd1);
        hold(1);
        check("deb_at_edge", {31'b0, dut.deb_q[0]}, 32'd0);
        hold(2);
        rot_a = 1'b1;
        hold(12);
        check("deb_restored", {31'b0, dut.deb_q[0]}, 32'd1);
        check("pulse_value_unchanged", {29'b0, value}, 32'd0);

        // Switch press and release.
        rot_sw = 1'b0;
        hold(2 + DC);
        check("sw_level_before", {31'b0, sw_level}, 32'd0);
        hold(1);
        check("sw_level_pressed", {31'b0, sw_level}, 32'd1);
        check("sw_press_pulse", {31'b0, sw_press}, 32'd1);
        hold(1);
        check("sw_press_width", {31'b0, sw_press}, 32'd0);
        hold(12);
        check("sw_press_count", press_cnt, 32'd1);
        rot_sw = 1'b1;
        hold(10);
        check("sw_level_released", {31'b0, sw_level}, 32'd0);
        check("sw_release_no_pulse", press_cnt, 32'd1);

        // Detent table: wrap, saturation, CCW from 0 and clear on the inc cycle.
        for (int i = 0; i < 15; i++) begin
            sb.push_back(tbl[i]);
            detent(tbl[i].cw, tbl[i].clr);
        end
        hold(5);
        check("table_all_pulses_seen", sb.size(), 32'd0);

        // Partial rotation that reverses produces no pulse.
        phase(1'b1, 1'b0, 1'b0);
        phase(1'b0, 1'b0, 1'b0);
        phase(1'b1, 1'b0, 1'b0);
        phase(1'b1, 1'b1, 1'b0);
        check("reverse_value", {29'b0, value}, 32'd1);
        check("reverse_value_sat", {29'b0, value_s}, 32'd1);

        // Both bits changing at once flags a sequence error and leaves the accumulator alone.
        s0 = seq_cnt;
        phase(1'b0, 1'b0, 1'b0);
        check("seq_err_single", seq_cnt - s0, 32'd1);
        check("seq_err_acc", {28'b0, dut.acc_q}, 32'd0);
        phase(1'b1, 1'b1, 1'b0);
        check("seq_err_second", seq_cnt - s0, 32'd2);
        check("seq_err_value", {29'b0, value}, 32'd1);

        // Reset in the middle of a detent.
        phase(1'b1, 1'b0, 1'b0);
        phase(1'b0, 1'b0, 1'b0);
        check("acc_mid_detent", {28'b0, dut.acc_q}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_value_clear", {29'b0, value}, 32'd0);
        check("async_acc_clear", {28'b0, dut.acc_q}, 32'd0);
        rot_a = 1'b1;
        rot_b = 1'b1;
        hold(3);
        rst_n = 1'b1;
        hold(5);
        post = '{1'b1, 1'b0, 1, 1};
        sb.push_back(post);
        detent(1'b1, 1'b0);
        hold(5);
        check("post_reset_one_pulse", sb.size(), 32'd0);
        check("post_reset_value", {29'b0, value}, 32'd1);

        hold(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
